// File: rtl/data_unit_param.sv
// Parametrised register file / ALU / RAM datapath with registered flags,
// carry chaining and an iterative shift-add multiplier behind a busy/done handshake.
module data_unit_param #(
  parameter int WIDTH     = 8,
  parameter int REG_COUNT = 4,
  parameter int RAM_DEPTH = 16,
  localparam int RSEL = $clog2(REG_COUNT),
  localparam int AW   = $clog2(RAM_DEPTH),
  localparam int CW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic [3:0]       operation_select,
  input  logic [RSEL-1:0]  a_select,
  input  logic [RSEL-1:0]  b_select,
  input  logic [RSEL-1:0]  destination_select,
  input  logic [WIDTH-1:0] constant_in,
  input  logic             mb_select,
  input  logic             md_select,
  input  logic             write_ram_enable,
  output logic [WIDTH-1:0] output_data,
  output logic             zero_flag,
  output logic             carrier_flag,
  output logic             negative_flag,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_PSB = 4'b0100, OP_XOR = 4'b0101,
                         OP_NOT = 4'b0110, OP_SHL = 4'b0111, OP_SHR = 4'b1000,
                         OP_ADC = 4'b1001, OP_SBB = 4'b1010, OP_MUL = 4'b1011;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  logic [WIDTH-1:0]   regs_q [REG_COUNT];
  logic [WIDTH-1:0]   regs_d [REG_COUNT];
  logic [WIDTH-1:0]   mem_q  [RAM_DEPTH];
  logic [WIDTH-1:0]   a_bus, b_bus, b_add, d_bus, alu_r, ram_rd;
  logic               alu_c, cin, ram_we;
  logic [WIDTH:0]     sum;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [RSEL-1:0]    mdest_q, mdest_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d, carry_q, carry_d, neg_q, neg_d, done_q, done_d;

  // Operand buses and single-cycle ALU
  always_comb begin
    a_bus  = regs_q[a_select];
    b_bus  = mb_select ? constant_in : regs_q[b_select];
    ram_rd = mem_q[a_bus[AW-1:0]];
    b_add  = b_bus;
    cin    = 1'b0;
    case (operation_select)
      OP_SUB:  begin b_add = ~b_bus; cin = 1'b1; end
      OP_ADC:  cin = carry_q;
      OP_SBB:  begin b_add = ~b_bus; cin = carry_q; end
      default: ;
    endcase
    sum   = {1'b0, a_bus} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
    alu_r = a_bus;
    alu_c = 1'b0;
    case (operation_select)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin alu_r = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      OP_AND:  alu_r = a_bus & b_bus;
      OP_OR:   alu_r = a_bus | b_bus;
      OP_XOR:  alu_r = a_bus ^ b_bus;
      OP_PSB:  alu_r = b_bus;
      OP_NOT:  alu_r = ~a_bus;
      OP_SHL:  begin alu_r = {a_bus[WIDTH-2:0], 1'b0}; alu_c = a_bus[WIDTH-1]; end
      OP_SHR:  begin alu_r = {1'b0, a_bus[WIDTH-1:1]}; alu_c = a_bus[0]; end
      default: ;
    endcase
    d_bus = md_select ? ram_rd : alu_r;
  end

  // Next-state: single-cycle writes in IDLE, one shift-add step per MUL_RUN cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mdest_d  = mdest_q;
    regs_d   = regs_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    ram_we   = 1'b0;
    acc_sum  = acc_q;
    case (state_q)
      IDLE: begin
        ram_we = write_ram_enable;
        if (load_enable) begin
          if (!md_select && operation_select == OP_MUL) begin
            state_d  = MUL_RUN;
            cnt_d    = CW'(WIDTH - 1);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_bus};
            mplier_d = b_bus;
            mdest_d  = destination_select;
          end else begin
            regs_d[destination_select] = d_bus;
            out_d = d_bus;
            if (!md_select) begin
              zero_d  = (alu_r == '0);
              neg_d   = alu_r[WIDTH-1];
              carry_d = alu_c;
            end
          end
        end
      end
      MUL_RUN: begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          regs_d[mdest_q] = acc_sum[WIDTH-1:0];
          out_d   = acc_sum[WIDTH-1:0];
          zero_d  = (acc_sum[WIDTH-1:0] == '0);
          neg_d   = acc_sum[WIDTH-1];
          carry_d = |acc_sum[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mdest_q  <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      out_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mdest_q  <= mdest_d;
      regs_q   <= regs_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  // RAM is deliberately not reset; a same-cycle load sees the pre-edge word
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[a_bus[AW-1:0]] <= b_bus;
  end

  assign output_data   = out_q;
  assign zero_flag     = zero_q;
  assign carrier_flag  = carry_q;
  assign negative_flag = neg_q;
  assign busy          = (state_q == MUL_RUN);
  assign done          = done_q;

endmodule
